// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO interrupt controller: edge-mode encodings
// and small helpers used by the top level and the debounce channel.
package gpio_pkg;

    // Per-channel edge selection, two bits per channel in irq_mode.
    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } irq_mode_t;

    // Decide whether a debounced transition is an interrupt event for the
    // given edge mode.
    function automatic logic edge_hit(input logic [1:0] mode,
                                      input logic       rise,
                                      input logic       fall);
        logic hit;
        hit = 1'b0;
        case (irq_mode_t'(mode))
            MODE_NONE: hit = 1'b0;
            MODE_RISE: hit = rise;
            MODE_FALL: hit = fall;
            MODE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Debounce counter width; a one-cycle window still needs one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// Register-style bus between a host and the GPIO interrupt controller:
// LED write port plus interrupt configuration and status.
interface gpio_irq_ctrl_if #(
    parameter int N_CH = 4
);
    logic                led_we;
    logic [N_CH-1:0]     led_wdata;
    logic [N_CH-1:0]     led_wmask;
    logic [N_CH-1:0]     led;
    logic [2*N_CH-1:0]   irq_mode;
    logic [N_CH-1:0]     irq_mask;
    logic [N_CH-1:0]     irq_clr;
    logic [N_CH-1:0]     irq_pend;
    logic                irq;

    // Host side: drives writes and configuration, observes status.
    modport master (
        output led_we, led_wdata, led_wmask, irq_mode, irq_mask, irq_clr,
        input  led, irq_pend, irq
    );

    // Controller side.
    modport slave (
        input  led_we, led_wdata, led_wmask, irq_mode, irq_mask, irq_clr,
        output led, irq_pend, irq
    );
endinterface

// File: rtl/gpio_debounce.sv
// One switch channel: two-flop synchronizer followed by a stability counter.
// The debounced state only follows the synchronized input after it has
// differed from the current state for DB_CYCLES consecutive clocks.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_out
);

    localparam int            CW      = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          state_reg;
    logic          state_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // Synchronizer and debounce state registers, cleared by active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            state_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= sw_in;
            sync2_reg <= sync1_reg;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Count while the input disagrees; accept it when the window is full.
    // The count never passes CNT_MAX because reaching it forces a load.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        if (sync2_reg != state_reg) begin
            if (cnt_reg == CNT_MAX) begin
                state_next = sync2_reg;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    assign sw_out = state_reg;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO block: debounced switch inputs with per-channel edge interrupts
// (pending flags, mask, write-1-to-clear) and a masked-write LED register.
module gpio_irq_ctrl
    import gpio_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  sw,
    output logic [N_CH-1:0]  sw_reg,
    gpio_irq_ctrl_if.slave   bus
);

    logic [N_CH-1:0] sw_prev_reg;
    logic [N_CH-1:0] event_hit;
    logic [N_CH-1:0] pend_reg;
    logic [N_CH-1:0] pend_next;
    logic [N_CH-1:0] led_reg;
    logic [N_CH-1:0] led_next;
    logic            irq_reg;
    logic            irq_next;

    // One synchronizer/debouncer per channel, plus its edge classifier.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            gpio_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .sw_in  (sw[gi]),
                .sw_out (sw_reg[gi])
            );

            assign event_hit[gi] = edge_hit(bus.irq_mode[2*gi +: 2],
                                            sw_reg[gi] & ~sw_prev_reg[gi],
                                            ~sw_reg[gi] & sw_prev_reg[gi]);
        end
    endgenerate

    // Next-state for pending flags, LED register and interrupt line.
    // A new event wins over a clear on the same edge so it is never lost.
    always_comb begin
        pend_next = (pend_reg & ~bus.irq_clr) | event_hit;
        led_next  = led_reg;
        if (bus.led_we) begin
            led_next = (led_reg & ~bus.led_wmask) | (bus.led_wdata & bus.led_wmask);
        end
        irq_next  = |(pend_reg & bus.irq_mask);
    end

    // Status and output registers; reset drops any in-flight event because
    // the previous-state copy of sw_reg is cleared together with sw_reg.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_prev_reg <= '0;
            pend_reg    <= '0;
            led_reg     <= '0;
            irq_reg     <= 1'b0;
        end else begin
            sw_prev_reg <= sw_reg;
            pend_reg    <= pend_next;
            led_reg     <= led_next;
            irq_reg     <= irq_next;
        end
    end

    assign bus.irq_pend = pend_reg;
    assign bus.led      = led_reg;
    assign bus.irq      = irq_reg;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Scoreboard bench for gpio_irq_ctrl: each stimulus cycle pushes the
// reference model's expected outputs; a monitor pops and compares after
// every rising edge. Directed scenarios come first, then random traffic.
module tb_gpio_irq_ctrl;

    localparam int N  = 4;
    localparam int DB = 4;

    typedef struct packed {
        logic [N-1:0] swr;
        logic [N-1:0] led;
        logic [N-1:0] pend;
        logic         irq;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] sw;
    logic [N-1:0] sw_reg;

    gpio_irq_ctrl_if #(.N_CH(N)) bus ();

    gpio_irq_ctrl #(
        .N_CH      (N),
        .DB_CYCLES (DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw),
        .sw_reg (sw_reg),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    // Reference model state: raw-input delay line, window of the last DB
    // synchronized samples, debounced value and its previous copy.
    logic [N-1:0] m_p1, m_p2, m_swr, m_swr_d, m_led, m_pend;
    logic         m_irq;
    logic [N-1:0] m_win [DB];

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        exp_t         e;
        logic [N-1:0] nswr;
        logic [N-1:0] ev;
        logic         stable, rise, fall;
        logic [1:0]   md;
        if (!rst) begin
            m_p1 = '0; m_p2 = '0; m_swr = '0; m_swr_d = '0;
            m_led = '0; m_pend = '0; m_irq = 1'b0;
            for (int j = 0; j < DB; j++) m_win[j] = '0;
        end else begin
            for (int j = DB - 1; j > 0; j--) m_win[j] = m_win[j-1];
            m_win[0] = m_p2;
            nswr = m_swr;
            ev   = '0;
            for (int i = 0; i < N; i++) begin
                // accept a new level only if the last DB samples all disagree
                stable = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (m_win[j][i] == m_swr[i]) stable = 1'b0;
                if (stable) nswr[i] = ~m_swr[i];
                rise  = m_swr[i] && !m_swr_d[i];
                fall  = !m_swr[i] && m_swr_d[i];
                md    = bus.irq_mode[2*i +: 2];
                ev[i] = (md[0] && rise) || (md[1] && fall);
            end
            m_irq  = |(m_pend & bus.irq_mask);
            m_pend = (m_pend & ~bus.irq_clr) | ev;
            if (bus.led_we)
                m_led = (m_led & ~bus.led_wmask) | (bus.led_wdata & bus.led_wmask);
            m_p2    = m_p1;
            m_p1    = sw;
            m_swr_d = m_swr;
            m_swr   = nswr;
        end
        e.swr = m_swr; e.led = m_led; e.pend = m_pend; e.irq = m_irq;
        exp_q.push_back(e);
    endtask

    // One stimulus cycle: inputs are already set while clk is low.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, req);
        end
    endtask

    // Monitor: compare every DUT output against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp += 4;
            if (sw_reg !== e.swr) begin
                n_err++;
                $display("FAIL sb_sw_reg cyc=%0d got=%b want=%b", cyc, sw_reg, e.swr);
            end
            if (bus.led !== e.led) begin
                n_err++;
                $display("FAIL sb_led cyc=%0d got=%b want=%b", cyc, bus.led, e.led);
            end
            if (bus.irq_pend !== e.pend) begin
                n_err++;
                $display("FAIL sb_pend cyc=%0d got=%b want=%b", cyc, bus.irq_pend, e.pend);
            end
            if (bus.irq !== e.irq) begin
                n_err++;
                $display("FAIL sb_irq cyc=%0d got=%b want=%b", cyc, bus.irq, e.irq);
            end
        end
    end

    initial begin
        int hold;
        rst = 1'b0; sw = '0;
        bus.led_we = 1'b0; bus.led_wdata = '0; bus.led_wmask = '0;
        bus.irq_mode = 8'h55; bus.irq_mask = 4'b0001; bus.irq_clr = '0;
        tick(2);
        check("reset_sw_reg", sw_reg, 4'b0000);
        check("reset_pend", bus.irq_pend, 4'b0000);
        check("reset_irq", {3'b000, bus.irq}, 4'b0000);
        rst = 1'b1;
        tick(3);

        // held input: sw_reg on 6th edge, pend on 7th, irq on 8th
        sw = 4'b0001;
        tick(5);
        check("hold_sw_reg_e5", sw_reg, 4'b0000);
        tick();
        check("hold_sw_reg_e6", sw_reg, 4'b0001);
        check("hold_pend_e6", bus.irq_pend, 4'b0000);
        tick();
        check("hold_pend_e7", bus.irq_pend, 4'b0001);
        check("hold_irq_e7", {3'b000, bus.irq}, 4'b0000);
        tick();
        check("hold_irq_e8", {3'b000, bus.irq}, 4'b0001);

        // three-cycle glitch on sw[2] is rejected
        sw = 4'b0101; tick(3);
        sw = 4'b0001; tick(10);
        check("glitch_sw_reg", sw_reg, 4'b0001);
        check("glitch_pend", bus.irq_pend, 4'b0001);

        // clear on the same edge as a new ch0 event keeps pend set
        bus.irq_mode = 8'h57;
        sw = 4'b0000; tick(6);
        bus.irq_clr = 4'b0001; tick();
        bus.irq_clr = 4'b0000;
        check("clr_vs_set_pend", bus.irq_pend, 4'b0001);
        bus.irq_clr = 4'b0001; tick();
        bus.irq_clr = 4'b0000;
        check("clr_pend", bus.irq_pend, 4'b0000);
        tick();
        check("clr_irq", {3'b000, bus.irq}, 4'b0000);

        // masked LED write
        bus.led_we = 1'b1; bus.led_wdata = 4'b1010; bus.led_wmask = 4'b1111; tick();
        bus.led_wdata = 4'b0101; bus.led_wmask = 4'b0011; tick();
        check("led_masked", bus.led, 4'b1001);
        bus.led_we = 1'b0; bus.led_wdata = 4'b1111; tick();
        check("led_hold", bus.led, 4'b1001);

        // falling-edge mode on ch1, masked, then unmasked
        bus.irq_mode = 8'h5B; bus.irq_mask = 4'b0000;
        sw = 4'b0010; tick(8);
        check("fall_rise_ignored", bus.irq_pend, 4'b0000);
        sw = 4'b0000; tick(7);
        check("fall_pend", bus.irq_pend, 4'b0010);
        check("fall_irq_masked", {3'b000, bus.irq}, 4'b0000);
        bus.irq_mask = 4'b0010; tick();
        check("fall_irq_unmasked", {3'b000, bus.irq}, 4'b0001);

        // reset mid-debounce and mid-pending
        bus.irq_mode = 8'hFF;
        sw = 4'b1111; tick(8);
        check("all_pend", bus.irq_pend, 4'b1111);
        sw = 4'b0000; tick(3);
        rst = 1'b0; tick();
        check("rst_sw_reg", sw_reg, 4'b0000);
        check("rst_led", bus.led, 4'b0000);
        check("rst_pend", bus.irq_pend, 4'b0000);
        check("rst_irq", {3'b000, bus.irq}, 4'b0000);
        rst = 1'b1; tick(10);
        check("post_rst_pend", bus.irq_pend, 4'b0000);
        check("post_rst_sw_reg", sw_reg, 4'b0000);

        // random traffic against the model
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                sw   = 4'($urandom);
                hold = $urandom_range(1, 9);
            end
            hold--;
            bus.led_we    = ($urandom_range(0, 3) == 0);
            bus.led_wdata = 4'($urandom);
            bus.led_wmask = 4'($urandom);
            bus.irq_clr   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 15) == 0) bus.irq_mode = 8'($urandom);
            if ($urandom_range(0, 15) == 0) bus.irq_mask = 4'($urandom);
            rst = ($urandom_range(0, 99) != 0);
            tick();
        end

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_irq_ctrl.md
GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input channels and number of LED output bits (range 1..32).
REQ-002 SHALL have parameter DB_CYCLES, default 4, debounce stability window in clk cycles (minimum 1).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port sw, input, N_CH, asynchronous raw switch inputs.
REQ-006 SHALL have port sw_reg, output, N_CH, debounced switch state.
REQ-007 SHALL have port led, output, N_CH, registered LED drive.
REQ-008 SHALL have port led_we, input, 1, LED write strobe.
REQ-009 SHALL have port led_wdata, input, N_CH, LED write data.
REQ-010 SHALL have port led_wmask, input, N_CH, per-bit LED write enable.
REQ-011 SHALL have port irq_mode, input, 2*N_CH, per-channel edge mode (bits 2i+1:2i for channel i).
REQ-012 SHALL have port irq_mask, input, N_CH, per-channel interrupt enable.
REQ-013 SHALL have port irq_clr, input, N_CH, write-1-to-clear pending strobe.
REQ-014 SHALL have port irq_pend, output, N_CH, pending interrupt flags.
REQ-015 SHALL have port irq, output, 1, registered interrupt request.

Function
REQ-016 Each sw bit SHALL pass through a two-flop synchronizer; the second-stage output is s[i].
REQ-017 Per channel, a counter SHALL increment while s[i] != sw_reg[i], clear to 0 while s[i] == sw_reg[i], and saturate at DB_CYCLES-1.
REQ-018 sw_reg[i] SHALL load s[i] on the edge where the counter equals DB_CYCLES-1 and s[i] != sw_reg[i], then the counter SHALL clear.
REQ-019 A sw change held stable SHALL appear on sw_reg on the (2+DB_CYCLES)th rising clk edge after the change; glitches shorter than DB_CYCLES cycles at s SHALL NOT change sw_reg.
REQ-020 Edge events SHALL be detected on sw_reg transitions: mode 00 none, 01 rising, 10 falling, 11 both.
REQ-021 A detected event SHALL set irq_pend[i] on the edge after sw_reg[i] changes, independent of irq_mask.
REQ-022 irq_clr[i]=1 SHALL clear irq_pend[i] on the next edge; simultaneous set and clear on the same channel SHALL leave pend set.
REQ-023 irq SHALL equal the registered OR of (irq_pend & irq_mask), one cycle behind irq_pend/irq_mask.
REQ-024 When led_we=1, led SHALL update next edge to (led & ~led_wmask) | (led_wdata & led_wmask); when led_we=0, led SHALL hold.
REQ-025 Changing irq_mode SHALL NOT by itself set or clear any pending flag.

Reset
REQ-026 While rst=0 at a clk edge, synchronizer flops, counters, sw_reg, led, irq_pend and irq SHALL all become 0.
REQ-027 After reset release, a sw bit held high SHALL produce a rising edge on sw_reg after 2+DB_CYCLES cycles (and pend if mode 01/11).
REQ-028 Reset asserted mid-debounce or mid-pending SHALL discard all in-progress state without generating an event.

Structure
REQ-029 Edge-mode encodings (MODE_NONE, MODE_RISE, MODE_FALL, MODE_BOTH) SHALL live in shared package gpio_pkg.
REQ-030 Synchronizer plus debounce counter SHALL be one sub-module gpio_debounce, instantiated N_CH times in a generate loop.
REQ-031 Counter width SHALL be clog2(DB_CYCLES) (minimum 1 bit).

Verification
REQ-032 N_CH=4, DB_CYCLES=4: sw=4'b0001 held -> sw_reg=4'b0001 on the 6th edge, irq_pend=4'b0001 on the 7th edge, irq=1 on the 8th edge with mode 01 and mask 4'b0001.
REQ-033 3-cycle pulse on sw[2] -> sw_reg, irq_pend and irq remain 0.
REQ-034 irq_pend[0]=1, irq_clr=4'b0001 pulsed on the same edge as a new event on ch0 -> pend stays 1; a later clr alone -> pend 0, irq 0 one cycle later.
REQ-035 led=4'b1010, led_we=1, led_wdata=4'b0101, led_wmask=4'b0011 -> led=4'b1001 next edge.
REQ-036 Mode 10 on ch1, mask 0: sw[1] 1->0 -> irq_pend[1]=1, irq=0; set mask[1]=1 -> irq=1 one edge later.
REQ-037 rst=0 asserted with a debounce count in flight and pend=4'b1111 -> all outputs 0 next edge, no event after release with sw=0.
